// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares the single mmio port between IFU (read-only) and LSU (read/write).
// Latency: accept at cycle N, mmio strobe at N+1, response valid at N+2 (3 cycles minimum).
// Backpressure: response held stable until owner's rsp_ready; no requests accepted until then.
// Optional macro ARB_RR_EN: round-robin arbitration instead of fixed LSU-over-IFU priority.
module mmio_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int WDT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_wen,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    input  logic [WDT_W-1:0]  ls_req_wdt_op,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [WDT_W-1:0]  mem_wdt_op,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        owner;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wen;
    logic [DATA_W-1:0] lat_wdata;
    logic [WDT_W-1:0]  lat_wdt;
    logic [DATA_W-1:0] rsp_q;
    logic              grant_ls;
    logic              grant_if;
    logic              accept;
    logic              rsp_hs;

`ifdef ARB_RR_EN
    // last_ls=0 means IFU was served last, so LSU wins the first tie after reset
    logic last_ls;

    // On a tie, the requester not served last wins; a lone requester always wins
    always_comb begin
        grant_ls = ls_req_valid && (!if_req_valid || !last_ls);
        grant_if = if_req_valid && !grant_ls;
    end

    // Remember who was granted at each acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_ls <= 1'b0;
        else if (accept)
            last_ls <= grant_ls;
    end
`else
    // Fixed priority: LSU always beats IFU
    always_comb begin
        grant_ls = ls_req_valid;
        grant_if = if_req_valid && !ls_req_valid;
    end
`endif

    assign accept = (state == IDLE) && (grant_ls || grant_if);
    assign rsp_hs = (state == RESP) &&
                    (((owner == OWN_IF) && if_rsp_ready) ||
                     ((owner == OWN_LS) && ls_rsp_ready));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: ACCESS always lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request, capture read data in ACCESS, release owner on response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_NONE;
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wdt   <= '0;
            rsp_q     <= '0;
        end else begin
            if (accept) begin
                owner     <= grant_ls ? OWN_LS : OWN_IF;
                lat_addr  <= grant_ls ? ls_req_addr : if_req_addr;
                lat_wen   <= grant_ls && ls_req_wen;
                lat_wdata <= grant_ls ? ls_req_wdata : '0;
                lat_wdt   <= grant_ls ? ls_req_wdt_op : '0;
            end
            if (state == ACCESS)
                rsp_q <= lat_wen ? '0 : mem_rdata;
            if (rsp_hs)
                owner <= OWN_NONE;
        end
    end

    // Outputs: ready only in IDLE to the winner, strobes only in ACCESS, responses only in RESP
    always_comb begin
        if_req_ready = (state == IDLE) && grant_if;
        ls_req_ready = (state == IDLE) && grant_ls;
        mem_raddr    = '0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        mem_wdt_op   = '0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = '0;
        busy         = (state != IDLE);
        if (state == ACCESS) begin
            mem_raddr  = lat_addr;
            mem_waddr  = lat_addr;
            mem_wdata  = lat_wdata;
            mem_wdt_op = lat_wdt;
            mem_ren    = !lat_wen;
            mem_wen    = lat_wen;
        end
        if (state == RESP) begin
            if (owner == OWN_IF) begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = rsp_q;
            end
            if (owner == OWN_LS) begin
                ls_rsp_valid = 1'b1;
                ls_rsp_data  = rsp_q;
            end
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed-vector bench for mmio_arbiter.
// Inputs change 1ns after the rising edge, outputs are sampled 2ns after it.
// mmio is modelled as a combinational read-data register driven by the bench.
module tb_mmio_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [31:0] if_req_addr;
    logic [63:0] if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid, ls_rsp_ready;
    logic [31:0] ls_req_addr;
    logic [63:0] ls_req_wdata, ls_rsp_data;
    logic [3:0]  ls_req_wdt_op;
    logic [31:0] mem_raddr, mem_waddr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wdt_op;
    logic        mem_ren, mem_wen, busy;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int snap;
    logic exp_ls;

    always #5 clk = ~clk;

    mmio_arbiter #(.ADDR_W(32), .DATA_W(64), .WDT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wdt_op(ls_req_wdt_op),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wdt_op(mem_wdt_op), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Count every mmio strobe seen at a clock edge
    always @(posedge clk) begin
        if (mem_ren || mem_wen) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 1;
        ls_req_valid = 0; ls_req_wen = 0; ls_req_addr = 0; ls_req_wdata = 0;
        ls_req_wdt_op = 0; ls_rsp_ready = 1; mem_rdata = 0;

        // Reset state
        settle();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ren", {63'd0, mem_ren}, 64'd0);
        chk("rst_if_rsp_valid", {63'd0, if_rsp_valid}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // IFU read
        tick();
        if_req_valid = 1; if_req_addr = 32'h8000_0000; mem_rdata = 64'h1122334455667788;
        settle();
        chk("if_rdy_c0", {63'd0, if_req_ready}, 64'd1);
        chk("ls_rdy_c0", {63'd0, ls_req_ready}, 64'd0);
        chk("ren_c0", {63'd0, mem_ren}, 64'd0);
        tick();
        if_req_valid = 0;
        settle();
        chk("ren_c1", {63'd0, mem_ren}, 64'd1);
        chk("raddr_c1", {32'd0, mem_raddr}, 64'h8000_0000);
        chk("wen_c1", {63'd0, mem_wen}, 64'd0);
        chk("busy_c1", {63'd0, busy}, 64'd1);
        tick();
        settle();
        chk("if_rsp_valid_c2", {63'd0, if_rsp_valid}, 64'd1);
        chk("if_rsp_data_c2", if_rsp_data, 64'h1122334455667788);
        chk("ren_c2", {63'd0, mem_ren}, 64'd0);
        chk("ls_rsp_valid_c2", {63'd0, ls_rsp_valid}, 64'd0);
        tick();
        settle();
        chk("idle_after_if", {63'd0, busy}, 64'd0);
        chk("raddr_idle", {32'd0, mem_raddr}, 64'd0);

        // LSU byte write
        ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 32'ha000_03f8;
        ls_req_wdata = 64'h5a; ls_req_wdt_op = 4'h1; mem_rdata = 64'hffff_0000_ffff_0000;
        settle();
        chk("ls_rdy_w", {63'd0, ls_req_ready}, 64'd1);
        tick();
        ls_req_valid = 0;
        settle();
        chk("wen_w", {63'd0, mem_wen}, 64'd1);
        chk("ren_w", {63'd0, mem_ren}, 64'd0);
        chk("waddr_w", {32'd0, mem_waddr}, 64'ha000_03f8);
        chk("wdata_w", mem_wdata, 64'h5a);
        chk("wdt_w", {60'd0, mem_wdt_op}, 64'h1);
        tick();
        settle();
        chk("ls_rsp_valid_w", {63'd0, ls_rsp_valid}, 64'd1);
        chk("ls_rsp_data_w", ls_rsp_data, 64'd0);
        chk("wen_after_w", {63'd0, mem_wen}, 64'd0);
        tick();
        ls_req_wen = 0;

        // Simultaneous reads, both held valid; reset first so round-robin history is fresh
        apply_reset();
        if_req_valid = 1; ls_req_valid = 1; mem_rdata = 64'h0123;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            settle();
            chk($sformatf("arb_ls_%0d", k), {63'd0, ls_req_ready}, {63'd0, exp_ls});
            chk($sformatf("arb_if_%0d", k), {63'd0, if_req_ready}, {63'd0, !exp_ls});
            tick();
            tick();
            tick();
        end
        if_req_valid = 0; ls_req_valid = 0;
        tick();

        // Backpressure on LSU read response
        ls_req_valid = 1; ls_req_addr = 32'h0000_1000; mem_rdata = 64'hcafe_f00d_1234_5678;
        ls_rsp_ready = 0;
        tick();
        ls_req_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_rdata = 64'hbad0_0000_0000_0000 + 64'(i);
            ls_req_valid = 1; if_req_valid = 1;
            settle();
            chk($sformatf("bp_vld_%0d", i), {63'd0, ls_rsp_valid}, 64'd1);
            chk($sformatf("bp_dat_%0d", i), ls_rsp_data, 64'hcafe_f00d_1234_5678);
            chk($sformatf("bp_rdy_%0d", i), {62'd0, ls_req_ready, if_req_ready}, 64'd0);
            chk($sformatf("bp_strobe_%0d", i), {62'd0, mem_ren, mem_wen}, 64'd0);
            tick();
        end
        if_req_valid = 0;
        ls_rsp_ready = 1;
        settle();
        chk("bp_hs_vld", {63'd0, ls_rsp_valid}, 64'd1);
        tick();
        settle();
        chk("bp_idle", {63'd0, busy}, 64'd0);
        chk("bp_rsp_gone", {63'd0, ls_rsp_valid}, 64'd0);
        chk("bp_new_rdy", {63'd0, ls_req_ready}, 64'd1);
        // Withdraw before the edge: must not be latched
        ls_req_valid = 0;
        tick();
        settle();
        chk("bp_withdraw_idle", {63'd0, busy}, 64'd0);

        // Reset during ACCESS
        if_req_valid = 1; if_req_addr = 32'h8000_0040; mem_rdata = 64'h77;
        tick();
        if_req_valid = 0;
        settle();
        chk("rst_mid_ren_pre", {63'd0, mem_ren}, 64'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_ren", {63'd0, mem_ren}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_raddr", {32'd0, mem_raddr}, 64'd0);
        tick();
        rst_n = 1;
        tick();
        settle();
        chk("rst_mid_no_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
        chk("rst_mid_idle", {63'd0, busy}, 64'd0);
        if_req_valid = 1; if_req_addr = 32'h8000_0080; mem_rdata = 64'haabb_ccdd_eeff_0011;
        settle();
        chk("post_rst_rdy", {63'd0, if_req_ready}, 64'd1);
        tick();
        if_req_valid = 0;
        settle();
        chk("post_rst_ren", {63'd0, mem_ren}, 64'd1);
        tick();
        settle();
        chk("post_rst_rsp", if_rsp_data, 64'haabb_ccdd_eeff_0011);
        chk("post_rst_vld", {63'd0, if_rsp_valid}, 64'd1);
        tick();

        // LSU request pulses while IFU response is held
        if_req_valid = 1; if_req_addr = 32'h8000_00c0; if_rsp_ready = 0; mem_rdata = 64'h99;
        tick();
        if_req_valid = 0;
        tick();
        snap = strobe_cnt;
        ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 32'h20;
        settle();
        chk("wd_ls_rdy", {63'd0, ls_req_ready}, 64'd0);
        chk("wd_if_vld", {63'd0, if_rsp_valid}, 64'd1);
        tick();
        ls_req_valid = 0; ls_req_wen = 0;
        if_rsp_ready = 1;
        tick();
        tick();
        tick();
        settle();
        chk("wd_no_strobe", 64'(strobe_cnt - snap), 64'd0);
        chk("wd_idle", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
